// File: rtl/fb_pkg.sv
// Shared defaults, width derivations and FSM encoding for the serial filter bank.
package fb_pkg;

  localparam int DATA_W_DEF   = 16;
  localparam int COEF_W_DEF   = 16;
  localparam int NUM_TAPS_DEF = 119;
  localparam int NUM_CH_DEF   = 16;

  // Headroom of clog2(taps) bits keeps the full-precision sum from wrapping.
  function automatic int fb_acc_w(input int data_w, input int coef_w, input int num_taps);
    return data_w + coef_w + $clog2(num_taps);
  endfunction

  function automatic int fb_tap_w(input int num_taps);
    return $clog2(num_taps);
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } fb_state_e;

endpackage

// File: rtl/fb_mac_lane.sv
// One sub-band channel: a tap-indexed coefficient bank and a full-precision accumulator.
module fb_mac_lane
  import fb_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int COEF_W   = COEF_W_DEF,
  parameter int NUM_TAPS = NUM_TAPS_DEF,
  parameter int ACC_W    = fb_acc_w(DATA_W_DEF, COEF_W_DEF, NUM_TAPS_DEF),
  parameter int TAP_W    = fb_tap_w(NUM_TAPS_DEF)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     coef_we,
  input  logic [TAP_W-1:0]         coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  input  logic [TAP_W-1:0]         rd_addr,
  input  logic signed [DATA_W-1:0] sample,
  input  logic                     clr,
  input  logic                     mac,
  output logic signed [ACC_W-1:0]  acc
);

  localparam int PROD_W = DATA_W + COEF_W;

  logic signed [COEF_W-1:0] coef_mem [NUM_TAPS];
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_q, acc_d;

  // Coefficients survive reset so a bank loaded once stays valid.
  always_ff @(posedge clock) begin
    if (coef_we) coef_mem[coef_addr] <= coef_data;
  end

  assign prod = PROD_W'(sample) * PROD_W'(coef_mem[rd_addr]);

  always_comb begin
    acc_d = acc_q;
    if (clr)      acc_d = '0;
    else if (mac) acc_d = acc_q + ACC_W'(prod);
  end

  always_ff @(posedge clock) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/filter_bank_serial.sv
// Serial multi-channel FIR bank: one shared delay line, one MAC per channel per tap cycle.
module filter_bank_serial
  import fb_pkg::*;
#(
  parameter int  DATA_W   = DATA_W_DEF,
  parameter int  COEF_W   = COEF_W_DEF,
  parameter int  NUM_TAPS = NUM_TAPS_DEF,
  parameter int  NUM_CH   = NUM_CH_DEF,
  localparam int ACC_W    = fb_acc_w(DATA_W, COEF_W, NUM_TAPS),
  localparam int TAP_W    = fb_tap_w(NUM_TAPS),
  localparam int CH_W     = $clog2(NUM_CH)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clk_enable,
  input  logic signed [DATA_W-1:0] filter_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     coef_we,
  input  logic [CH_W-1:0]          coef_ch,
  input  logic [TAP_W-1:0]         coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic [NUM_CH*ACC_W-1:0]  filter_out,
  output logic                     out_valid
);

  fb_state_e                state_q, state_d;
  logic [TAP_W-1:0]         tap_cnt_q, tap_cnt_d;
  logic                     valid_q, valid_d;
  logic signed [DATA_W-1:0] dline_q [NUM_TAPS];
  logic [NUM_CH*ACC_W-1:0]  out_q, acc_all;
  logic                     accept, mac_step, coef_ok;

  always_comb begin
    state_d   = state_q;
    tap_cnt_d = tap_cnt_q;
    valid_d   = 1'b0;
    accept    = 1'b0;
    mac_step  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept    = 1'b1;
          tap_cnt_d = '0;
          state_d   = MAC;
        end
      end
      MAC: begin
        mac_step = 1'b1;
        if (tap_cnt_q == TAP_W'(NUM_TAPS - 1)) state_d = DONE;
        else                                   tap_cnt_d = tap_cnt_q + 1'b1;
      end
      DONE: begin
        valid_d   = 1'b1;
        tap_cnt_d = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      tap_cnt_q <= '0;
      valid_q   <= 1'b0;
      out_q     <= '0;
      for (int i = 0; i < NUM_TAPS; i++) dline_q[i] <= '0;
    end else if (clk_enable) begin
      state_q   <= state_d;
      tap_cnt_q <= tap_cnt_d;
      valid_q   <= valid_d;
      if (state_q == DONE) out_q <= acc_all;
      if (accept) begin
        dline_q[0] <= filter_in;
        for (int i = 1; i < NUM_TAPS; i++) dline_q[i] <= dline_q[i-1];
      end
    end
  end

  // Writes land only while idle; sizes that are not powers of two leave unused codes to reject.
  assign coef_ok = coef_we & clk_enable & ~reset & (state_q == IDLE)
                 & ({1'b0, coef_addr} < (TAP_W + 1)'(NUM_TAPS))
                 & ({1'b0, coef_ch} < (CH_W + 1)'(NUM_CH));

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    fb_mac_lane #(
      .DATA_W   (DATA_W),
      .COEF_W   (COEF_W),
      .NUM_TAPS (NUM_TAPS),
      .ACC_W    (ACC_W),
      .TAP_W    (TAP_W)
    ) u_lane (
      .clock     (clock),
      .reset     (reset),
      .coef_we   (coef_ok && (coef_ch == CH_W'(c))),
      .coef_addr (coef_addr),
      .coef_data (coef_data),
      .rd_addr   (tap_cnt_q),
      .sample    (dline_q[tap_cnt_q]),
      .clr       (clk_enable & accept),
      .mac       (clk_enable & mac_step),
      .acc       (acc_all[c*ACC_W +: ACC_W])
    );
  end

  assign in_ready   = (state_q == IDLE);
  assign filter_out = out_q;
  assign out_valid  = valid_q & clk_enable;

endmodule
